// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: owns the PC, prefetches words into a small FIFO and
// hands them to decode over valid/ready; a redirect flushes and reloads.
module inst_fetch_unit #(
    parameter int ADDR_W   = 10,
    parameter int INST_W   = 16,
    parameter int DEPTH    = 2,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    output logic [ADDR_W-1:0] inst_addr,
    input  logic [INST_W-1:0] inst_in,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [ADDR_W-1:0] out_pc,
    output logic [15:0]       fetch_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] fifo_inst [DEPTH];
    logic [ADDR_W-1:0] fifo_pc   [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic              push;
    logic              pop;

    assign inst_addr = pc;
    assign out_valid = (count != '0) && !redirect;
    assign pop       = out_valid && out_ready;
    // A full FIFO may still accept a word when the head leaves this cycle.
    assign push      = fetch_en && !redirect &&
                       ((count < CNT_W'(DEPTH)) || pop);
    assign out_inst  = fifo_inst[rd_ptr];
    assign out_pc    = fifo_pc[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc        <= ADDR_W'(RESET_PC);
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            fetch_cnt <= '0;
        end else if (redirect) begin
            pc     <= redirect_pc;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                pc     <= pc + ADDR_W'(1);
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                if (fetch_cnt != 16'hFFFF) begin
                    fetch_cnt <= fetch_cnt + 16'd1;
                end
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Storage needs no reset: entries are only visible while count != 0.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_inst[wr_ptr] <= inst_in;
            fifo_pc[wr_ptr]   <= pc;
        end
    end

endmodule
